// File: rtl/gamma_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : gamma_sequencer_if
// Description : Host/primitive signal bundle for the gamma-cycle sequencer.
//               The slave side is the sequencer; the master side is the
//               host plus the race-logic primitives it drives and samples.
// Revision    : 1.0 - initial release
// ============================================================================
interface gamma_sequencer_if #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int NUM_IN            = 2,
  parameter int NUM_OUT           = 1
);
  localparam int TW = $clog2(GAMMA_CYCLE_WIDTH) + 1;

  logic                   start;
  logic                   mode;
  logic [NUM_IN*TW-1:0]   in_times;
  logic [NUM_OUT-1:0]     result;
  logic                   set;
  logic [NUM_IN-1:0]      spikes;
  logic                   busy;
  logic                   done;
  logic [NUM_OUT*TW-1:0]  out_times;

  modport master (
    output start, mode, in_times, result,
    input  set, spikes, busy, done, out_times
  );

  modport slave (
    input  start, mode, in_times, result,
    output set, spikes, busy, done, out_times
  );
endinterface
`default_nettype wire

// File: rtl/gamma_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gamma_sequencer
// Description : Runs one race-logic gamma cycle: arms the SR latches, encodes
//               the latched spike times onto the spike lines as steps or
//               pulses, and time-stamps the first high sample of each
//               primitive output.
// Revision    : 1.0 - initial release
// ============================================================================
module gamma_sequencer #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int NUM_IN            = 2,
  parameter int NUM_OUT           = 1
) (
  input wire logic         aclk,
  input wire logic         grst_n,
  gamma_sequencer_if.slave bus
);

  localparam int TW = $clog2(GAMMA_CYCLE_WIDTH) + 1;
  // "No spike" marker; real time stamps are always below it.
  localparam logic [TW-1:0] T_INF  = TW'(GAMMA_CYCLE_WIDTH);
  localparam logic [TW-1:0] T_LAST = TW'(GAMMA_CYCLE_WIDTH - 1);
  // One extra bit so time + PULSE_WIDTH cannot wrap.
  localparam logic [TW:0]   PW_EXT = (TW+1)'(PULSE_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SET  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic                   set_w;
  logic                   busy_w;
  logic                   done_w;
  logic                   run_w;
  logic                   accept_w;

  logic [TW-1:0]          t_cnt;
  logic [NUM_IN*TW-1:0]   times_q;
  logic                   mode_q;
  logic [NUM_IN-1:0]      spikes_w;
  logic [NUM_OUT*TW-1:0]  out_times_q;

  // A start request is only honoured while idle; no queueing.
  assign accept_w = (state == S_IDLE) && bus.start;

  // State register.
  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_next = state;
    set_w      = 1'b0;
    busy_w     = 1'b1;
    done_w     = 1'b0;
    run_w      = 1'b0;
    case (state)
      S_IDLE: begin
        busy_w = 1'b0;
        if (bus.start) begin
          state_next = S_SET;
        end
      end
      S_SET: begin
        set_w      = 1'b1;
        state_next = S_RUN;
      end
      S_RUN: begin
        run_w = 1'b1;
        if (t_cnt == T_LAST) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done_w     = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Capture the job parameters on accept and run the window time counter.
  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      times_q <= '0;
      mode_q  <= 1'b0;
      t_cnt   <= '0;
    end else begin
      if (accept_w) begin
        times_q <= bus.in_times;
        mode_q  <= bus.mode;
      end
      if (state == S_SET) begin
        t_cnt <= '0;
      end else if (state == S_RUN) begin
        t_cnt <= t_cnt + 1'b1;
      end
    end
  end

  // Spike encoders: purely a decode of the registered counter and latched
  // times, so no input can reach the spike lines combinationally. Spikes
  // are gated to RUN, which also truncates pulses at the window end and
  // keeps them low while set is high.
  for (genvar i = 0; i < NUM_IN; i++) begin : g_enc
    logic [TW:0] time_ext;
    logic [TW:0] t_ext;
    logic [TW:0] end_ext;
    logic        step_hit;
    logic        pulse_hit;

    assign time_ext  = {1'b0, times_q[i*TW +: TW]};
    assign t_ext     = {1'b0, t_cnt};
    assign end_ext   = time_ext + PW_EXT;
    assign step_hit  = (t_ext >= time_ext);
    assign pulse_hit = step_hit && (t_ext < end_ext);
    assign spikes_w[i] = run_w && (mode_q ? pulse_hit : step_hit);
  end

  // Result decoders: each lane keeps the first time its primitive was seen
  // high; the lane is re-armed to "no spike" when a new job is accepted.
  for (genvar j = 0; j < NUM_OUT; j++) begin : g_dec
    always_ff @(posedge aclk or negedge grst_n) begin
      if (!grst_n) begin
        out_times_q[j*TW +: TW] <= T_INF;
      end else if (accept_w) begin
        out_times_q[j*TW +: TW] <= T_INF;
      end else if (run_w && bus.result[j] &&
                   (out_times_q[j*TW +: TW] == T_INF)) begin
        out_times_q[j*TW +: TW] <= t_cnt;
      end
    end
  end

  assign bus.set       = set_w;
  assign bus.busy      = busy_w;
  assign bus.done      = done_w;
  assign bus.spikes    = spikes_w;
  assign bus.out_times = out_times_q;

endmodule
`default_nettype wire

// File: tb/tb_gamma_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gamma_sequencer
// Description : Directed bench for gamma_sequencer. A greater_than primitive
//               (q = a & ~latched(b fired)) closes the loop from spikes to
//               result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gamma_sequencer;

  localparam int GCW = 16;
  localparam int PW  = 8;

  logic aclk   = 1'b0;
  logic grst_n = 1'b0;
  logic use_gt = 1'b0;
  logic b_l;
  int   passed = 0;
  int   total  = 0;
  int   fails  = 0;
  int   done_cnt;

  gamma_sequencer_if #(.GAMMA_CYCLE_WIDTH(GCW), .NUM_IN(2), .NUM_OUT(1)) bus ();

  gamma_sequencer #(
    .GAMMA_CYCLE_WIDTH(GCW),
    .PULSE_WIDTH(PW),
    .NUM_IN(2),
    .NUM_OUT(1)
  ) dut (
    .aclk  (aclk),
    .grst_n(grst_n),
    .bus   (bus.slave)
  );

  always #5 aclk = ~aclk;

  // greater_than primitive: b's latch is cleared by set, set by b's spike.
  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n)          b_l <= 1'b0;
    else if (bus.set)     b_l <= 1'b0;
    else if (bus.spikes[1]) b_l <= 1'b1;
  end
  assign bus.result = use_gt & bus.spikes[0] & ~b_l;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic exp_spike(input logic m, input int tm, input int t);
    if (tm >= GCW) return 1'b0;
    if (m) return (t >= tm) && (t < tm + PW);
    return (t >= tm);
  endfunction

  task automatic do_run(input logic m, input int a, input int b, input logic gt,
                        input int exp_out, input string tag);
    logic [1:0] exp_sp;
    @(negedge aclk);
    bus.start    = 1'b1;
    bus.mode     = m;
    bus.in_times = {5'(b), 5'(a)};
    use_gt       = gt;
    @(negedge aclk);
    bus.start = 1'b0;
    chk({tag, " set"}, 32'(bus.set), 1);
    chk({tag, " set_spk"}, 32'(bus.spikes), 0);
    chk({tag, " set_busy"}, 32'(bus.busy), 1);
    for (int t = 0; t < GCW; t++) begin
      @(negedge aclk);
      exp_sp = {exp_spike(m, b, t), exp_spike(m, a, t)};
      chk($sformatf("%s spk t=%0d", tag, t), 32'(bus.spikes), 32'(exp_sp));
      chk($sformatf("%s run_done t=%0d", tag, t), 32'(bus.done | bus.set), 0);
    end
    @(negedge aclk);
    chk({tag, " done"}, 32'(bus.done), 1);
    chk({tag, " done_spk"}, 32'(bus.spikes), 0);
    chk({tag, " out"}, 32'(bus.out_times), 32'(exp_out));
    @(negedge aclk);
    chk({tag, " idle_done"}, 32'(bus.done), 0);
    chk({tag, " idle_busy"}, 32'(bus.busy), 0);
    chk({tag, " hold_out"}, 32'(bus.out_times), 32'(exp_out));
  endtask

  initial begin
    // Reset with random inputs.
    bus.start    = 1'($urandom);
    bus.mode     = 1'($urandom);
    bus.in_times = 10'($urandom);
    #12;
    chk("rst set", 32'(bus.set), 0);
    chk("rst spikes", 32'(bus.spikes), 0);
    chk("rst busy", 32'(bus.busy), 0);
    chk("rst done", 32'(bus.done), 0);
    chk("rst out", 32'(bus.out_times), 16);
    @(negedge aclk);
    bus.start = 1'b0;
    grst_n    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      chk($sformatf("idle busy %0d", i), 32'(bus.busy | bus.done | bus.set), 0);
    end
    chk("idle out", 32'(bus.out_times), 16);

    // Step mode through the greater_than primitive.
    do_run(1'b0, 3, 7, 1'b1, 3, "step37");
    do_run(1'b0, 7, 3, 1'b1, 16, "step73");
    // No spike, result tied low.
    do_run(1'b0, 16, 16, 1'b0, 16, "nospk");
    // Time zero fires in the first RUN cycle.
    do_run(1'b0, 0, 5, 1'b1, 0, "step05");
    // Pulse mode: truncated pulse and full-width pulse.
    do_run(1'b1, 12, 16, 1'b1, 12, "pulse12");
    do_run(1'b1, 2, 16, 1'b1, 2, "pulse2");

    // start pulsed during RUN and DONE is ignored.
    @(negedge aclk);
    bus.start = 1'b1; bus.mode = 1'b0; bus.in_times = {5'd7, 5'd3}; use_gt = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge aclk);
      bus.start = (i == 5) || (i == 17);
      if (bus.done) done_cnt++;
      if (i == 17) chk("hs done_at_17", 32'(bus.done), 1);
      if (i == 30) chk("hs idle_busy", 32'(bus.busy), 0);
    end
    bus.start = 1'b0;
    chk("hs one_done", 32'(done_cnt), 1);

    // start held high: back-to-back runs every GCW+3 cycles.
    @(negedge aclk);
    bus.start = 1'b1;
    done_cnt  = 0;
    for (int i = 0; i < 56; i++) begin
      @(negedge aclk);
      if (bus.done) done_cnt++;
      if (i % 19 == 0)  chk($sformatf("b2b set i=%0d", i), 32'(bus.set), 1);
      if (i % 19 == 1)  chk($sformatf("b2b clr i=%0d", i), 32'(bus.out_times), 16);
      if (i % 19 == 17) begin
        chk($sformatf("b2b done i=%0d", i), 32'(bus.done), 1);
        chk($sformatf("b2b out i=%0d", i), 32'(bus.out_times), 3);
      end
    end
    bus.start = 1'b0;
    chk("b2b done_cnt", 32'(done_cnt), 3);
    repeat (3) @(negedge aclk);
    chk("b2b drained", 32'(bus.busy), 0);

    // Reset mid-run at t=5.
    @(negedge aclk);
    bus.start = 1'b1; bus.mode = 1'b0; bus.in_times = {5'd7, 5'd3}; use_gt = 1'b1;
    @(negedge aclk);
    bus.start = 1'b0;
    repeat (6) @(negedge aclk);
    chk("mid t5 spk", 32'(bus.spikes), 1);
    chk("mid t5 out", 32'(bus.out_times), 3);
    #2 grst_n = 1'b0;
    #1;
    chk("mid busy", 32'(bus.busy), 0);
    chk("mid spikes", 32'(bus.spikes), 0);
    chk("mid set", 32'(bus.set), 0);
    chk("mid out", 32'(bus.out_times), 16);
    done_cnt = 0;
    repeat (4) begin
      @(negedge aclk);
      if (bus.done) done_cnt++;
    end
    chk("mid no_done", 32'(done_cnt), 0);
    grst_n = 1'b1;
    do_run(1'b0, 3, 7, 1'b1, 3, "post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gamma_sequencer.md
# gamma_sequencer

Sequencer for one gamma cycle of race-logic evaluation around the temporal primitives (greater_than, min/max, SR-latch based units). On a host `start` it pulses `set` to arm every SR latch, then counts GAMMA_CYCLE_WIDTH `aclk` cycles while encoding the latched integer spike times as edges or pulses on `spikes`. It time-stamps the first high sample of each primitive output on `result` and returns the decoded times with a one-cycle `done`.

## Interface
- GAMMA_CYCLE_WIDTH, 16: clock cycles per gamma window; a time value ≥ this is "no spike" (∞).
- PULSE_WIDTH, 8: spike length in cycles in pulse mode.
- NUM_IN, 2: number of encoded spike lines.
- NUM_OUT, 1: number of decoded result lines.
- TW (localparam): $clog2(GAMMA_CYCLE_WIDTH)+1, the time field width; ∞ is encoded as GAMMA_CYCLE_WIDTH.

Ports:
- aclk  in  1  sole clock, rising edge.
- grst_n  in  1  asynchronous active-low reset.
- start  in  1  request a gamma cycle; sampled only in IDLE.
- mode  in  1  0 = step (edge) encoding, 1 = pulse encoding; latched with start.
- in_times  in  NUM_IN*TW  spike time per input, lane i at [i*TW +: TW]; latched with start.
- result  in  NUM_OUT  primitive outputs (q), sampled every RUN cycle.
- set  out  1  latch arm pulse to the primitives.
- spikes  out  NUM_IN  encoded spike lines to the primitives.
- busy  out  1  high in SET, RUN and DONE.
- done  out  1  one-cycle completion pulse.
- out_times  out  NUM_OUT*TW  decoded first-spike time per result lane.

## Operation
- FSM states: IDLE, SET, RUN, DONE.
- IDLE: `busy`=0. `start`=1 latches `in_times` and `mode`, then moves to SET. Otherwise stays in IDLE.
- SET: lasts exactly 1 cycle.
  - `set`=1, `spikes`=0.
  - Time counter t cleared to 0; all `out_times` lanes cleared to ∞.
  - Moves to RUN.
- RUN: lasts GAMMA_CYCLE_WIDTH cycles, t = 0 … GAMMA_CYCLE_WIDTH-1, incrementing each cycle.
- Encoding, decoded from the registered t and the latched times only (no combinational path from inputs to `spikes`):
  - Step mode: `spikes[i]` = (t ≥ time_i).
  - Pulse mode: `spikes[i]` = (time_i ≤ t < time_i+PULSE_WIDTH).
  - The comparison uses TW+1 bits so time_i+PULSE_WIDTH cannot wrap.
  - A pulse that would run past the window end is truncated there.
  - time_i ≥ GAMMA_CYCLE_WIDTH never spikes.
- Decoding:
  - `result[j]` is sampled at the end of each RUN cycle.
  - Lane j captures t on the first cycle it is sampled 1 while the lane still holds ∞; later samples do not overwrite it.
  - A lane never sampled high stays ∞.
- After the RUN cycle with t = GAMMA_CYCLE_WIDTH-1, move to DONE.
- DONE: lasts 1 cycle. `done`=1, `spikes`=0, then move to IDLE.
- `out_times` hold their values from DONE until the next SET.
- `start` is ignored in SET, RUN and DONE; there is no queueing.

## Timing
- Reset (grst_n=0, asynchronous) values:
  - State IDLE.
  - `set`=0, `spikes`=0, `busy`=0, `done`=0.
  - Every `out_times` lane = GAMMA_CYCLE_WIDTH.
  - Latched times and mode = 0.
- Reset asserted mid-operation aborts immediately to the reset values; no `done` is produced.
- Latency: `start` sampled at edge k → SET during cycle k+1 → RUN cycles k+2 … k+1+GAMMA_CYCLE_WIDTH → `done` in cycle k+2+GAMMA_CYCLE_WIDTH.
- Throughput: a `start` held high in the cycle after DONE is accepted, giving one gamma cycle every GAMMA_CYCLE_WIDTH+3 cycles.
- `set` and `spikes` are never high in the same cycle.
- time_i = 0 drives `spikes[i]` high in the first RUN cycle.
- `out_times` lanes change only in SET (cleared) or on their capture cycle.

## Test plan
- **Reset values:** assert grst_n=0 with random inputs → all outputs at reset values, `out_times`=16. Release reset, start=0 for 20 cycles → outputs unchanged.
- **Step mode, greater_than model** (q = a & ~latched(b fired)): mode=0, times (3,7).
  - Required: `set` in cycle k+1; `spikes[0]` rises at t=3; `spikes[1]` rises at t=7.
  - Required: `done` in cycle k+18 with `out_times`=3.
  - Repeat with times (7,3) → `out_times`=16.
- **No spike:** times (16,16) with result tied low → `spikes` stays 0 throughout and `out_times`=16. Times (0,5) → `spikes[0]` high from the first RUN cycle.
- **Pulse mode:** mode=1, time 12, PULSE_WIDTH=8 → `spikes[0]` high only for t=12…15 (truncated) and low in DONE. Time 2 → high for t=2…9.
- **Handshake:** `start` pulsed during RUN and DONE → ignored, exactly one `done`. `start` held high continuously → back-to-back runs every 19 cycles, `out_times` cleared to 16 at each SET.
- **Reset mid-run:** grst_n=0 at t=5 → immediately `busy`=0, `spikes`=0, no `done`. A following `start` completes a normal run with correct `out_times`.
